mips_stage_decode: RTL and testbench

MIPS_STAGE_DECODE -- requirements
Module: mips_stage_decode

---
 rtl/mips_stage_decode_pkg.sv | 123 ++++++++++++
 rtl/mips_datapath_regfile.sv | 47 ++++
 rtl/mips_stage_decode.sv | 240 ++++++++++++++++++++++++
 tb/tb_mips_stage_decode.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_stage_decode_pkg.sv
// Shared MIPS types: opcodes, funct codes, stage bundles, FSM encoding.
// Bypass behaviour is selected by MIPS_STAGE_DECODE_BYPASS_EN.
package mips_stage_decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2a;
  localparam logic [5:0] F_SLTU = 6'h2b;

  typedef enum logic [3:0] {
    ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND,
    ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT,
    ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_LUI, ALU_LINK
  } alu_op_e;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

  typedef struct packed {
    logic clk;
    logic rst_n;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] pcAddr;
    logic        valid;
  } pc_reg_t;

  typedef struct packed {
    logic        stall;
    logic        squash;
    logic        taken;
    logic        replay;
    logic [31:0] target;
  } pc_ctrl_t;

  typedef struct packed {
    logic [31:0] regPort1;
    logic        regPortEq;
    pc_ctrl_t    control;
  } reg_pc_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pcAddr;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic [31:0] immSext;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [4:0]  dst;
    alu_op_e     aluOp;
    logic        aluSrc;
    logic        memRead;
    logic        memWrite;
    logic        memToReg;
    logic        regWrite;
  } reg_ex_t;

  localparam int REG_EX_W = $bits(reg_ex_t);
  typedef logic [REG_EX_W-1:0] reg_ex_vec_t;

  function automatic reg_ex_vec_t reg_ex_pack(input reg_ex_t e);
    return reg_ex_vec_t'(e);
  endfunction

  function automatic reg_ex_t reg_ex_unpack(input reg_ex_vec_t v);
    return reg_ex_t'(v);
  endfunction

  function automatic alu_op_e alu_from_funct(input logic [5:0] f);
    alu_op_e a;
    case (f)
      F_SLL:          a = ALU_SLL;
      F_SRL:          a = ALU_SRL;
      F_SRA:          a = ALU_SRA;
      F_ADD, F_ADDU:  a = ALU_ADD;
      F_SUB, F_SUBU:  a = ALU_SUB;
      F_AND:          a = ALU_AND;
      F_OR:           a = ALU_OR;
      F_XOR:          a = ALU_XOR;
      F_NOR:          a = ALU_NOR;
      F_SLT:          a = ALU_SLT;
      F_SLTU:         a = ALU_SLTU;
      default:        a = ALU_NOP;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/mips_datapath_regfile.sv
// REG_L x 32 register file, r0 hard-wired to zero, async clear.
// MIPS_STAGE_DECODE_BYPASS_EN forwards same-cycle writeback data to reads.
module mips_datapath_regfile #(
  parameter  int REG_L = 32,
  localparam int REG_W = $clog2(REG_L)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [REG_W-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [REG_W-1:0] raddr1_i,
  input  logic [REG_W-1:0] raddr2_i,
  output logic [31:0]      rdata1_o,
  output logic [31:0]      rdata2_o
);

  logic [31:0] mem_q [REG_L];
  logic        wr_ok;

  assign wr_ok = we_i && (waddr_i != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < REG_L; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_ok) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata1_o = (raddr1_i == '0) ? '0 : mem_q[raddr1_i];
`ifdef MIPS_STAGE_DECODE_BYPASS_EN
    if (wr_ok && (waddr_i == raddr1_i)) rdata1_o = wdata_i;
`endif
  end

  always_comb begin
    rdata2_o = (raddr2_i == '0) ? '0 : mem_q[raddr2_i];
`ifdef MIPS_STAGE_DECODE_BYPASS_EN
    if (wr_ok && (waddr_i == raddr2_i)) rdata2_o = wdata_i;
`endif
  end

endmodule

// File: rtl/mips_stage_decode.sv
// MIPS decode stage: regfile read, hazard stall FSM, branch resolve, ID/EX reg.
// Without MIPS_STAGE_DECODE_BYPASS_EN a same-cycle writeback match stalls.
module mips_stage_decode
  import mips_stage_decode_pkg::*;
#(
  parameter  int DELAYED = 1,
  parameter  int REG_L   = 32,
  localparam int REG_W   = $clog2(REG_L)
) (
  input  ctrl_t            ctrl,
  input  pc_reg_t          pipePcReg,
  input  logic             wbEn,
  input  logic [REG_W-1:0] wbAddr,
  input  logic [31:0]      wbData,
  input  logic             exMemRead,
  input  logic             exRegWrite,
  input  logic [REG_W-1:0] exDst,
  output reg_pc_t          pipeRegPc,
  output reg_ex_t          pipeRegEx
);

  logic clk, rst_n;
  assign clk   = ctrl.clk;
  assign rst_n = ctrl.rst_n;

  logic [31:0] instr;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  assign instr = pipePcReg.instruction;
  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign shamt = instr[10:6];
  assign funct = instr[5:0];
  assign imm   = instr[15:0];

  logic [REG_W-1:0] rs_a, rt_a;
  assign rs_a = REG_W'(rs);
  assign rt_a = REG_W'(rt);

  logic [31:0] rs_val, rt_val;
  logic        rs_eq;

  mips_datapath_regfile #(
    .REG_L(REG_L)
  ) u_regfile (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .we_i    (wbEn),
    .waddr_i (wbAddr),
    .wdata_i (wbData),
    .raddr1_i(rs_a),
    .raddr2_i(rt_a),
    .rdata1_o(rs_val),
    .rdata2_o(rt_val)
  );

  assign rs_eq = (rs_val == rt_val);

  logic is_r, is_jr, is_rop, is_shift, is_beq, is_bne, is_br;
  logic is_j, is_jal, is_lw, is_sw, is_lui, is_logi, is_arith;
  assign is_r     = (op == OP_RTYPE);
  assign is_jr    = is_r && (funct == F_JR);
  assign is_rop   = is_r && !is_jr;
  assign is_shift = is_r && (funct == F_SLL || funct == F_SRL
                          || funct == F_SRA);
  assign is_beq   = (op == OP_BEQ);
  assign is_bne   = (op == OP_BNE);
  assign is_br    = is_beq || is_bne;
  assign is_j     = (op == OP_J);
  assign is_jal   = (op == OP_JAL);
  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign is_lui   = (op == OP_LUI);
  assign is_logi  = (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  assign is_arith = (op == OP_ADDI) || (op == OP_ADDIU)
                 || (op == OP_SLTI) || (op == OP_SLTIU);

  logic uses_rs, uses_rt;
  assign uses_rs = (is_r && !is_shift) || is_br || is_lw || is_sw
                || is_logi || is_arith;
  assign uses_rt = is_rop || is_br || is_sw;

  logic squash_q, squash_d;
  logic slot_ok;
  // The slot behind a squashing branch is dead: no hazards, no redirect.
  assign slot_ok = pipePcReg.valid && !squash_q;

  logic hz_load, hz_branch, hz_wb, hazard;
  assign hz_load = exMemRead && (exDst != '0)
                && ((uses_rs && exDst == rs_a)
                 || (uses_rt && exDst == rt_a));
  assign hz_branch = (is_br || is_jr) && exRegWrite && (exDst != '0)
                  && (exDst == rs_a || exDst == rt_a);
`ifdef MIPS_STAGE_DECODE_BYPASS_EN
  assign hz_wb = 1'b0;
`else
  assign hz_wb = wbEn && (wbAddr != '0)
              && ((uses_rs && wbAddr == rs_a)
               || (uses_rt && wbAddr == rt_a));
`endif
  assign hazard = slot_ok && (hz_load || hz_branch || hz_wb);

  state_e state_q, state_d;
  logic   stall, replay;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (hazard) state_d = STALL;
      STALL:   state_d = hazard ? STALL : RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall  = hazard;
    replay = (state_q == STALL);
  end

  logic        br_taken, taken, squash;
  logic [31:0] pc4, target;
  assign br_taken = (is_beq && rs_eq) || (is_bne && !rs_eq)
                 || is_j || is_jal || is_jr;
  assign taken    = slot_ok && br_taken && !stall;
  assign squash   = (DELAYED == 0) && taken;
  assign pc4      = pipePcReg.pcAddr + 32'd4;

  always_comb begin
    target = pc4 + {{14{imm[15]}}, imm, 2'b00};
    if (is_j || is_jal) target = {pc4[31:28], instr[25:0], 2'b00};
    if (is_jr)          target = rs_val;
  end

  assign squash_d = squash;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) squash_q <= 1'b0;
    else        squash_q <= squash_d;
  end

  reg_ex_t     ex_d;
  reg_ex_vec_t ex_q;

  always_comb begin
    ex_d = '0;
    if (slot_ok && !stall) begin
      ex_d.valid   = 1'b1;
      ex_d.pcAddr  = pipePcReg.pcAddr;
      ex_d.rsData  = rs_val;
      ex_d.rtData  = rt_val;
      ex_d.immSext = is_logi ? {16'h0, imm} : {{16{imm[15]}}, imm};
      ex_d.rs      = rs;
      ex_d.rt      = rt;
      ex_d.rd      = rd;
      ex_d.shamt   = shamt;
      ex_d.funct   = funct;
      unique case (1'b1)
        is_rop: begin
          ex_d.aluOp    = alu_from_funct(funct);
          ex_d.regWrite = 1'b1;
          ex_d.dst      = rd;
        end
        is_jal: begin
          ex_d.aluOp    = ALU_LINK;
          ex_d.regWrite = 1'b1;
          ex_d.dst      = 5'd31;
        end
        is_br: ex_d.aluOp = ALU_SUB;
        is_lw: begin
          ex_d.aluOp    = ALU_ADD;
          ex_d.aluSrc   = 1'b1;
          ex_d.memRead  = 1'b1;
          ex_d.memToReg = 1'b1;
          ex_d.regWrite = 1'b1;
          ex_d.dst      = rt;
        end
        is_sw: begin
          ex_d.aluOp    = ALU_ADD;
          ex_d.aluSrc   = 1'b1;
          ex_d.memWrite = 1'b1;
        end
        is_arith: begin
          case (op)
            OP_SLTI:  ex_d.aluOp = ALU_SLT;
            OP_SLTIU: ex_d.aluOp = ALU_SLTU;
            default:  ex_d.aluOp = ALU_ADD;
          endcase
          ex_d.aluSrc   = 1'b1;
          ex_d.regWrite = 1'b1;
          ex_d.dst      = rt;
        end
        is_logi: begin
          case (op)
            OP_ANDI: ex_d.aluOp = ALU_AND;
            OP_ORI:  ex_d.aluOp = ALU_OR;
            default: ex_d.aluOp = ALU_XOR;
          endcase
          ex_d.aluSrc   = 1'b1;
          ex_d.regWrite = 1'b1;
          ex_d.dst      = rt;
        end
        is_lui: begin
          ex_d.aluOp    = ALU_LUI;
          ex_d.aluSrc   = 1'b1;
          ex_d.regWrite = 1'b1;
          ex_d.dst      = rt;
        end
        default: ex_d.aluOp = ALU_NOP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= reg_ex_pack(ex_d);
  end

  assign pipeRegEx = reg_ex_unpack(ex_q);

  // PC-facing controls read zero while reset is held.
  always_comb begin
    pipeRegPc                = '0;
    pipeRegPc.regPort1       = rs_val;
    pipeRegPc.regPortEq      = rs_eq;
    pipeRegPc.control.stall  = stall && rst_n;
    pipeRegPc.control.squash = squash && rst_n;
    pipeRegPc.control.taken  = taken && rst_n;
    pipeRegPc.control.replay = replay;
    pipeRegPc.control.target = target;
  end

endmodule

// File: tb/tb_mips_stage_decode.sv
// Directed bench for mips_stage_decode (DELAYED=1 and DELAYED=0 copies).
// Covers both MIPS_STAGE_DECODE_BYPASS_EN builds.
module tb_mips_stage_decode;
  import mips_stage_decode_pkg::*;

  logic    clk = 1'b0;
  logic    rst_n = 1'b1;
  ctrl_t   ctrl;
  pc_reg_t pipePcReg;
  logic        wbEn;
  logic [4:0]  wbAddr;
  logic [31:0] wbData;
  logic        exMemRead, exRegWrite;
  logic [4:0]  exDst;
  reg_pc_t rp1, rp0;
  reg_ex_t ex1, ex0;

  int checks = 0;
  int failures = 0;

  assign ctrl = '{clk: clk, rst_n: rst_n};

  always #5 clk = ~clk;

  mips_stage_decode #(.DELAYED(1)) dut (
    .ctrl(ctrl), .pipePcReg(pipePcReg),
    .wbEn(wbEn), .wbAddr(wbAddr), .wbData(wbData),
    .exMemRead(exMemRead), .exRegWrite(exRegWrite), .exDst(exDst),
    .pipeRegPc(rp1), .pipeRegEx(ex1)
  );

  mips_stage_decode #(.DELAYED(0)) dut0 (
    .ctrl(ctrl), .pipePcReg(pipePcReg),
    .wbEn(wbEn), .wbAddr(wbAddr), .wbData(wbData),
    .exMemRead(exMemRead), .exRegWrite(exRegWrite), .exDst(exDst),
    .pipeRegPc(rp0), .pipeRegEx(ex0)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] s,
      input logic [4:0] t, input logic [4:0] d, input logic [5:0] f);
    return {6'h00, s, t, d, 5'h00, f};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] o,
      input logic [4:0] s, input logic [4:0] t, input logic [15:0] i);
    return {o, s, t, i};
  endfunction

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
    pipePcReg = '{instruction: ins, pcAddr: pc, valid: 1'b1};
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wbEn = 1'b1;
    wbAddr = a;
    wbData = d;
  endtask

  initial begin
    pipePcReg = '0;
    wbEn = 0; wbAddr = 0; wbData = 0;
    exMemRead = 0; exRegWrite = 0; exDst = 0;

    // reset
    #1 rst_n = 1'b0;
    #1;
    chk("rst_state", 64'(dut.state_q), 64'(RUN));
    chk("rst_ex_zero", 64'(|ex1), 64'd0);
    chk("rst_stall", 64'(rp1.control.stall), 64'd0);
    chk("rst_squash", 64'(rp0.control.squash), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // write r5, then decode add r6,r5,r0
    wb(5'd5, 32'h12345678);
    #1;
    chk("bubble_nostall", 64'(rp1.control.stall), 64'd0);
    step();
    chk("bubble_ex_valid", 64'(ex1.valid), 64'd0);
    wbEn = 0;
    issue(rtype(5'd5, 5'd0, 5'd6, F_ADD), 32'h100);
    #1;
    chk("r5_port1", 64'(rp1.regPort1), 64'h12345678);
    step();
    chk("add_valid", 64'(ex1.valid), 64'd1);
    chk("add_rsData", 64'(ex1.rsData), 64'h12345678);
    chk("add_rtData", 64'(ex1.rtData), 64'd0);
    chk("add_dst", 64'(ex1.dst), 64'd6);
    chk("add_pc", 64'(ex1.pcAddr), 64'h100);
    chk("add_regwrite", 64'(ex1.regWrite), 64'd1);

    // r0 ignores writes
    pipePcReg = '0;
    wb(5'd0, 32'hFFFFFFFF);
    step();
    wbEn = 0;
    issue(rtype(5'd0, 5'd5, 5'd7, F_ADD), 32'h104);
    #1;
    chk("r0_port1", 64'(rp1.regPort1), 64'd0);
    step();
    chk("r0_rsData", 64'(ex1.rsData), 64'd0);
    chk("r0_rtData", 64'(ex1.rtData), 64'h12345678);

    // preload r1=r2=7, r8=0x88
    pipePcReg = '0;
    wb(5'd1, 32'd7); step();
    wb(5'd2, 32'd7); step();
    wb(5'd8, 32'h88); step();
    wbEn = 0;

    // load-use
    exMemRead = 1; exDst = 5'd8;
    issue(rtype(5'd8, 5'd8, 5'd9, F_ADD), 32'h108);
    #1;
    chk("lu_stall", 64'(rp1.control.stall), 64'd1);
    step();
    chk("lu_bubble", 64'(ex1.valid), 64'd0);
    chk("lu_state", 64'(dut.state_q), 64'(STALL));
    exMemRead = 0; exDst = 0;
    #1;
    chk("lu_unstall", 64'(rp1.control.stall), 64'd0);
    chk("lu_replay", 64'(rp1.control.replay), 64'd1);
    step();
    chk("lu_issue_valid", 64'(ex1.valid), 64'd1);
    chk("lu_issue_rs", 64'(ex1.rsData), 64'h88);
    chk("lu_state_run", 64'(dut.state_q), 64'(RUN));

    // taken beq, delayed vs squashed slot
    issue(itype(OP_BEQ, 5'd1, 5'd2, 16'h0004), 32'h200);
    #1;
    chk("beq_eq", 64'(rp1.regPortEq), 64'd1);
    chk("beq_taken", 64'(rp1.control.taken), 64'd1);
    chk("beq_target", 64'(rp1.control.target), 64'h214);
    chk("beq_d1_squash", 64'(rp1.control.squash), 64'd0);
    chk("beq_d0_squash", 64'(rp0.control.squash), 64'd1);
    step();
    issue(rtype(5'd1, 5'd2, 5'd10, F_ADD), 32'h204);
    step();
    chk("slot_d1_valid", 64'(ex1.valid), 64'd1);
    chk("slot_d0_valid", 64'(ex0.valid), 64'd0);

    // branch hazard with squash pending: stall wins
    exRegWrite = 1; exDst = 5'd1;
    issue(itype(OP_BEQ, 5'd1, 5'd2, 16'h0008), 32'h300);
    #1;
    chk("bh_stall", 64'(rp0.control.stall), 64'd1);
    chk("bh_no_squash", 64'(rp0.control.squash), 64'd0);
    step();
    chk("bh_bubble", 64'(ex0.valid), 64'd0);
    exRegWrite = 0; exDst = 0;
    #1;
    chk("bh_resquash", 64'(rp0.control.squash), 64'd1);
    step();
    issue(rtype(5'd1, 5'd2, 5'd11, F_SUB), 32'h304);
    step();
    chk("bh_slot_d0", 64'(ex0.valid), 64'd0);
    chk("bh_slot_d1", 64'(ex1.valid), 64'd1);

    // immediate extension
    issue(itype(OP_ORI, 5'd0, 5'd11, 16'h8000), 32'h400);
    step();
    chk("ori_zext", 64'(ex1.immSext), 64'h00008000);
    issue(itype(OP_ADDI, 5'd0, 5'd11, 16'h8000), 32'h404);
    step();
    chk("addi_sext", 64'(ex1.immSext), 64'hFFFF8000);

    // same-cycle writeback of a source register
    wb(5'd3, 32'hA5);
    issue(rtype(5'd3, 5'd0, 5'd12, F_ADD), 32'h408);
    #1;
`ifdef MIPS_STAGE_DECODE_BYPASS_EN
    chk("byp_stall", 64'(rp1.control.stall), 64'd0);
    chk("byp_port1", 64'(rp1.regPort1), 64'hA5);
    step();
    wbEn = 0;
    chk("byp_valid", 64'(ex1.valid), 64'd1);
    chk("byp_rsData", 64'(ex1.rsData), 64'hA5);
`else
    chk("nobyp_stall", 64'(rp1.control.stall), 64'd1);
    step();
    chk("nobyp_bubble", 64'(ex1.valid), 64'd0);
    wbEn = 0;
    #1;
    chk("nobyp_unstall", 64'(rp1.control.stall), 64'd0);
    step();
    chk("nobyp_valid", 64'(ex1.valid), 64'd1);
    chk("nobyp_rsData", 64'(ex1.rsData), 64'hA5);
`endif

    // reset in the middle of a stall
    issue(rtype(5'd8, 5'd8, 5'd9, F_ADD), 32'h500);
    step();
    chk("pre_rst_valid", 64'(ex1.valid), 64'd1);
    exMemRead = 1; exDst = 5'd8;
    issue(rtype(5'd8, 5'd0, 5'd9, F_ADD), 32'h504);
    step();
    chk("pre_rst_state", 64'(dut.state_q), 64'(STALL));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_state", 64'(dut.state_q), 64'(RUN));
    chk("mid_rst_stall", 64'(rp1.control.stall), 64'd0);
    chk("mid_rst_ex", 64'(|ex1), 64'd0);
    chk("mid_rst_r8", 64'(rp1.regPort1), 64'd0);
    exMemRead = 0; exDst = 0;
    pipePcReg = '0;
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_state", 64'(dut.state_q), 64'(RUN));
    chk("post_rst_stall", 64'(rp1.control.stall), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
